// File: rtl/apb_relay_sequencer_if.sv
// Command handshake and APB requester signals shared by the relay sequencer
// (master modport) and its command source / APB completer (slave modport).
interface apb_relay_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_channel;
  logic                  cmd_dir;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  logic                  busy;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_channel, cmd_dir, pready, prdata, pslverr,
    output cmd_ready, done, err, err_code, busy,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_channel, cmd_dir, pready, prdata, pslverr,
    input  cmd_ready, done, err, err_code, busy,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_relay_sequencer.sv
// APB requester: writes a relay toggle command, then polls the status busy bit
// until it clears. Define RELAY_SEQ_PREADY_WATCHDOG_EN to abort stalled accesses.
module apb_relay_sequencer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] TOGGLE_ADDR = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] STAT_ADDR   = 16'h0020,
  parameter int                    POLL_GAP    = 32,
  parameter int                    MAX_POLLS   = 4096
) (
  input logic                   pclk,
  input logic                   preset_n,
  apb_relay_sequencer_if.master bus
);

  if (DATA_WIDTH != 16) begin : g_bad_data_width
    $error("apb_relay_sequencer: DATA_WIDTH must be 16");
  end
  if (POLL_GAP < 1) begin : g_bad_poll_gap
    $error("apb_relay_sequencer: POLL_GAP must be at least 1");
  end
  if (MAX_POLLS < 1) begin : g_bad_max_polls
    $error("apb_relay_sequencer: MAX_POLLS must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_ACCESS,
    S_GAP,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    CODE_OK      = 2'd0,
    CODE_WR_ERR  = 2'd1,
    CODE_RD_ERR  = 2'd2,
    CODE_TIMEOUT = 2'd3
  } code_t;

  localparam int              GCW        = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int              PCW        = $clog2(MAX_POLLS + 1);
  localparam logic [GCW-1:0]  GAP_LAST   = GCW'(POLL_GAP - 1);
  localparam logic [PCW-1:0]  POLL_LIMIT = PCW'(MAX_POLLS);

  state_t         state_q, state_d;
  code_t          code_q, code_d;
  logic [1:0]     chan_q, chan_d;
  logic           dir_q, dir_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [PCW-1:0] poll_inc;
  logic           wdog_expired;

  logic                  cmd_ready;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  logic                  busy;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  rdata_unused;

  // Only the busy flag of the status register matters here.
  assign rdata_unused = ^bus.prdata[DATA_WIDTH-1:1];

  // Gating with preset_n keeps cmd_ready low while reset is held.
  assign cmd_ready = (state_q == S_IDLE) && preset_n;
  assign poll_inc  = poll_q + PCW'(1);

`ifdef RELAY_SEQ_PREADY_WATCHDOG_EN
  logic [15:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = '0;
    if (((state_q == S_WR_ACCESS) || (state_q == S_RD_ACCESS)) && !bus.pready) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_expired = (wdog_q == 16'hFFFF);
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    chan_d   = chan_q;
    dir_d    = dir_q;
    gap_d    = '0;
    poll_d   = poll_q;
    done     = 1'b0;
    err      = 1'b0;
    err_code = 2'd0;
    busy     = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          chan_d  = bus.cmd_channel;
          dir_d   = bus.cmd_dir;
          poll_d  = '0;
          code_d  = CODE_OK;
          state_d = S_WR_SETUP;
        end
      end

      S_WR_SETUP, S_WR_ACCESS: begin
        busy    = 1'b1;
        psel    = 1'b1;
        penable = (state_q == S_WR_ACCESS);
        pwrite  = 1'b1;
        paddr   = TOGGLE_ADDR;
        pwdata  = {dir_q, 13'b0, chan_q};
        if (state_q == S_WR_SETUP) begin
          state_d = S_WR_ACCESS;
        end else if (bus.pready) begin
          if (bus.pslverr) begin
            code_d  = CODE_WR_ERR;
            state_d = S_FINISH;
          end else begin
            state_d = S_GAP;
          end
        end else if (wdog_expired) begin
          code_d  = CODE_TIMEOUT;
          state_d = S_FINISH;
        end
      end

      S_GAP: begin
        busy = 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d = S_RD_SETUP;
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end

      S_RD_SETUP, S_RD_ACCESS: begin
        busy    = 1'b1;
        psel    = 1'b1;
        penable = (state_q == S_RD_ACCESS);
        paddr   = STAT_ADDR;
        if (state_q == S_RD_SETUP) begin
          state_d = S_RD_ACCESS;
        end else if (bus.pready) begin
          if (bus.pslverr) begin
            code_d  = CODE_RD_ERR;
            state_d = S_FINISH;
          end else if (!bus.prdata[0]) begin
            code_d  = CODE_OK;
            state_d = S_FINISH;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == POLL_LIMIT) begin
              code_d  = CODE_TIMEOUT;
              state_d = S_FINISH;
            end else begin
              state_d = S_GAP;
            end
          end
        end else if (wdog_expired) begin
          code_d  = CODE_TIMEOUT;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        done     = 1'b1;
        err      = (code_q != CODE_OK);
        err_code = code_q;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state: asynchronous reset drops the APB strobes immediately.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= S_IDLE;
      code_q  <= CODE_OK;
      gap_q   <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
    end
  end

  // Latched command payload; only observed while a command is in flight.
  always_ff @(posedge pclk) begin
    chan_q <= chan_d;
    dir_q  <= dir_d;
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.err_code  = err_code;
  assign bus.busy      = busy;
  assign bus.psel      = psel;
  assign bus.penable   = penable;
  assign bus.pwrite    = pwrite;
  assign bus.paddr     = paddr;
  assign bus.pwdata    = pwdata;

endmodule

// File: tb/tb_apb_relay_sequencer.sv
// Directed bench for apb_relay_sequencer with a behavioural APB completer
// (configurable wait states, slverr and number of busy status reads).
module tb_apb_relay_sequencer;
  localparam int PG = 4;
  localparam int MP = 8;

  logic pclk = 1'b0;
  logic preset_n;

  apb_relay_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  apb_relay_sequencer #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .TOGGLE_ADDR(16'h0000),
    .STAT_ADDR  (16'h0020),
    .POLL_GAP   (PG),
    .MAX_POLLS  (MP)
  ) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  int checks;
  int failures;

  // Completer configuration (written by the stimulus block only)
  int   cfg_waits;
  int   cfg_busy_polls;
  logic cfg_wr_err;
  logic cfg_rd_err;

  // Completer observations (written by the completer block only)
  int          n_wr, n_rd, n_done, stab_err, rd_bad, b2b_err, proto_err, rdy_err;
  int          rd_since_wr, wcnt;
  logic        acc_active, prev_cpl;
  logic [15:0] wr_addr, wr_data, snap_addr, snap_data;
  logic        snap_wr;

  // Results captured by run_cmd
  int          r_lat, r_busy_bad;
  logic        r_done, r_err, r_busy_at_done;
  logic [1:0]  r_code;
  logic        r_s_psel, r_s_pen, r_s_pwrite;
  logic [15:0] r_s_paddr, r_s_pwdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] ch, input logic d);
    @(negedge pclk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_channel = ch;
    bus.cmd_dir     = d;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    r_s_psel   = bus.psel;
    r_s_pen    = bus.penable;
    r_s_pwrite = bus.pwrite;
    r_s_paddr  = bus.paddr;
    r_s_pwdata = bus.pwdata;
    r_busy_bad = 0;
    r_lat      = 1;
    while (!bus.done && r_lat < 400) begin
      if (!bus.busy) r_busy_bad++;
      @(negedge pclk);
      r_lat++;
    end
    r_done         = bus.done;
    r_err          = bus.err;
    r_code         = bus.err_code;
    r_busy_at_done = bus.busy;
  endtask

  // Behavioural APB completer and protocol monitor, evaluated on falling edges.
  initial begin
    bus.pready = 1'b0; bus.prdata = 16'h0000; bus.pslverr = 1'b0;
    n_wr = 0; n_rd = 0; n_done = 0; stab_err = 0; rd_bad = 0;
    b2b_err = 0; proto_err = 0; rdy_err = 0; rd_since_wr = 0; wcnt = 0;
    acc_active = 1'b0; prev_cpl = 1'b0;
    wr_addr = 16'h0; wr_data = 16'h0; snap_addr = 16'h0; snap_data = 16'h0; snap_wr = 1'b0;
    forever begin
      @(negedge pclk);
      if (prev_cpl && bus.psel) b2b_err++;
      if (bus.penable && !bus.psel) proto_err++;
      if (bus.psel && !bus.busy) proto_err++;
      if (bus.cmd_ready && bus.busy) rdy_err++;
      if (bus.done) n_done++;
      prev_cpl = 1'b0;
      if (bus.psel && bus.penable) begin
        if (!acc_active) begin
          acc_active = 1'b1;
          wcnt       = 0;
          snap_addr  = bus.paddr;
          snap_data  = bus.pwdata;
          snap_wr    = bus.pwrite;
        end else if (bus.paddr !== snap_addr || bus.pwdata !== snap_data || bus.pwrite !== snap_wr) begin
          stab_err++;
        end
        if (wcnt < cfg_waits) begin
          // Misleading data while not ready: must be ignored by the requester.
          wcnt++;
          bus.pready  = 1'b0;
          bus.pslverr = 1'b1;
          bus.prdata  = 16'h0000;
        end else begin
          bus.pready = 1'b1;
          prev_cpl   = 1'b1;
          acc_active = 1'b0;
          if (bus.pwrite) begin
            n_wr++;
            wr_addr     = bus.paddr;
            wr_data     = bus.pwdata;
            rd_since_wr = 0;
            bus.pslverr = cfg_wr_err;
            bus.prdata  = 16'h0000;
          end else begin
            n_rd++;
            if (bus.paddr !== 16'h0020 || bus.pwdata !== 16'h0000) rd_bad++;
            bus.pslverr = cfg_rd_err;
            bus.prdata  = (rd_since_wr < cfg_busy_polls) ? 16'h0001 : 16'h0000;
            rd_since_wr++;
          end
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = 16'h0000;
        acc_active  = 1'b0;
      end
    end
  end

  initial begin
    int   base_wr, base_rd, base_done, acc, seen;
    logic found;
    checks = 0; failures = 0;
    preset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_channel = 2'd0; bus.cmd_dir = 1'b0;
    cfg_waits = 0; cfg_busy_polls = 0; cfg_wr_err = 1'b0; cfg_rd_err = 1'b0;

    // Reset state
    repeat (2) @(negedge pclk);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmd_ready_held", bus.cmd_ready, 0);
    chk("rst_err_code", bus.err_code, 0);
    preset_n = 1'b1;
    #1 chk("rst_cmd_ready_rel", bus.cmd_ready, 1);

    // 1: busy for 3 polls, ch=2 dir=1
    cfg_busy_polls = 3;
    base_wr = n_wr; base_rd = n_rd;
    run_cmd(2'd2, 1'b1);
    chk("t1_setup_psel", r_s_psel, 1);
    chk("t1_setup_penable", r_s_pen, 0);
    chk("t1_setup_pwrite", r_s_pwrite, 1);
    chk("t1_setup_paddr", r_s_paddr, 16'h0000);
    chk("t1_setup_pwdata", r_s_pwdata, 16'h8002);
    chk("t1_done", r_done, 1);
    chk("t1_latency", r_lat, 27);
    chk("t1_err", r_err, 0);
    chk("t1_code", r_code, 0);
    chk("t1_busy_during", r_busy_bad, 0);
    chk("t1_busy_at_done", r_busy_at_done, 0);
    chk("t1_writes", n_wr - base_wr, 1);
    chk("t1_wr_addr", wr_addr, 16'h0000);
    chk("t1_wr_data", wr_data, 16'h8002);
    chk("t1_reads", n_rd - base_rd, 4);

    // 2: slverr on the write
    cfg_busy_polls = 0; cfg_wr_err = 1'b1;
    base_rd = n_rd;
    run_cmd(2'd1, 1'b0);
    cfg_wr_err = 1'b0;
    chk("t2_done", r_done, 1);
    chk("t2_latency", r_lat, 3);
    chk("t2_err", r_err, 1);
    chk("t2_code", r_code, 1);
    chk("t2_reads", n_rd - base_rd, 0);
    chk("t2_wr_data", wr_data, 16'h0001);

    // 3: busy never clears -> timeout after MAX_POLLS reads
    cfg_busy_polls = 1000;
    base_rd = n_rd;
    run_cmd(2'd0, 1'b1);
    chk("t3_done", r_done, 1);
    chk("t3_latency", r_lat, 51);
    chk("t3_err", r_err, 1);
    chk("t3_code", r_code, 3);
    chk("t3_reads", n_rd - base_rd, 8);

    // 4: 5 wait states per access
    cfg_busy_polls = 3; cfg_waits = 5;
    base_rd = n_rd; base_wr = n_wr;
    run_cmd(2'd2, 1'b1);
    chk("t4_done", r_done, 1);
    chk("t4_latency", r_lat, 52);
    chk("t4_err", r_err, 0);
    chk("t4_code", r_code, 0);
    chk("t4_reads", n_rd - base_rd, 4);
    chk("t4_writes", n_wr - base_wr, 1);
    chk("t4_wr_data", wr_data, 16'h8002);
    chk("t4_stable", stab_err, 0);

    // 5: reset asserted during a read access
    cfg_busy_polls = 1000; cfg_waits = 3;
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_channel = 2'd3; bus.cmd_dir = 1'b0;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.psel && bus.penable && !bus.pwrite) found = 1'b1;
      else @(negedge pclk);
    end
    chk("t5_rd_access_seen", found, 1);
    base_done = n_done;
    #1 preset_n = 1'b0;
    #1;
    chk("t5_psel_async", bus.psel, 0);
    chk("t5_penable_async", bus.penable, 0);
    chk("t5_busy_rst", bus.busy, 0);
    chk("t5_done_rst", bus.done, 0);
    cfg_busy_polls = 0; cfg_waits = 0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    #1 chk("t5_cmd_ready_rel", bus.cmd_ready, 1);
    repeat (3) @(negedge pclk);
    chk("t5_no_done", n_done - base_done, 0);
    run_cmd(2'd1, 1'b0);
    chk("t5_next_done", r_done, 1);
    chk("t5_next_latency", r_lat, 9);
    chk("t5_next_code", r_code, 0);
    chk("t5_next_wr_data", wr_data, 16'h0001);

    // 6: cmd_valid held high for three commands
    base_wr = n_wr; base_rd = n_rd; base_done = n_done;
    acc = 0; seen = 0;
    bus.cmd_channel = 2'd3; bus.cmd_dir = 1'b1;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 200 && seen < 3; c++) begin
      if (bus.done) seen++;
      if (bus.cmd_ready) begin
        if (acc < 3) acc++;
        else bus.cmd_valid = 1'b0;
      end
      if (seen < 3) @(negedge pclk);
    end
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("t6_done_seen", seen, 3);
    chk("t6_accepts", acc, 3);
    chk("t6_done_count", n_done - base_done, 3);
    chk("t6_writes", n_wr - base_wr, 3);
    chk("t6_reads", n_rd - base_rd, 3);
    chk("t6_wr_data", wr_data, 16'h8003);

    // Protocol invariants over the whole run
    chk("inv_back_to_back", b2b_err, 0);
    chk("inv_psel_penable", proto_err, 0);
    chk("inv_ready_while_busy", rdy_err, 0);
    chk("inv_read_addr", rd_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_relay_sequencer.md
Name: apb_relay_sequencer

Overview:
APB requester that drives the relay controller's register map on behalf of firmware-free logic, such as front-panel or trigger-crossbar automation. It accepts relay toggle commands on a valid/ready interface and issues an APB write to the toggle register. It then polls the status register until the busy flag clears, and reports completion or error per command. It sits between the command source and the relay controller's APB completer on the same pclk domain.

Parameters:
ADDR_WIDTH, 16, APB address width
DATA_WIDTH, 16, APB data width; any other value is a synthesis error
TOGGLE_ADDR, 16'h0000, toggle register address
STAT_ADDR, 16'h0020, status register address (bit 0 = busy)
POLL_GAP, 32, idle cycles between status reads (minimum 1)
MAX_POLLS, 4096, status reads before timeout error

Ports:
pclk  in  1  clock
preset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer idle and accepting a command
cmd_channel  in  2  relay channel
cmd_dir  in  1  1 = in, 0 = out
done  out  1  one-cycle pulse when a command finishes (success or error)
err  out  1  valid with done; 1 = command failed
err_code  out  2  valid with done: 0 ok, 1 write slverr, 2 read slverr, 3 poll timeout
busy  out  1  command in progress
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  APB ready
prdata  in  DATA_WIDTH  APB read data
pslverr  in  1  APB error

Behaviour:
- One clock; reset is asynchronous and active-low (pclk, preset_n). On reset all outputs are 0 except cmd_ready, which is 1 once preset_n is high. The FSM enters IDLE and the counters clear.
- States: IDLE, WR_SETUP, WR_ACCESS, GAP, RD_SETUP, RD_ACCESS, FINISH.
- IDLE: cmd_ready = 1. When cmd_valid && cmd_ready, latch channel/dir, set busy = 1, and go to WR_SETUP next cycle.
- WR_SETUP: psel = 1, penable = 0, pwrite = 1, paddr = TOGGLE_ADDR, pwdata = {dir, 13'b0, channel}. Next state is WR_ACCESS.
- WR_ACCESS: penable = 1; all APB outputs are held stable until pready. On pready with pslverr, go to FINISH with code 1. On pready without pslverr, go to GAP.
- GAP: APB is idle with psel = 0. Count POLL_GAP cycles, then go to RD_SETUP.
- RD_SETUP/RD_ACCESS: same as the write phases but pwrite = 0, paddr = STAT_ADDR, pwdata = 0. Sample prdata/pslverr only in the cycle with pready = 1.
  - pslverr: code 2.
  - prdata[0] = 0: code 0.
  - Otherwise increment the poll counter; if the counter has reached MAX_POLLS, code 3, else GAP.
- FINISH: done = 1 for exactly one cycle, err = (code != 0), err_code is driven. busy drops the same cycle. Next state is IDLE.
- Against the zero-wait-state completer: write takes 2 cycles, each poll takes POLL_GAP + 2 cycles. Minimum command latency from accept to done is 2 + POLL_GAP + 2 + 1 cycles.
- psel/penable never assert outside the setup/access states. penable is never high without psel. Back-to-back transfers always pass through an idle cycle (GAP or IDLE).
- cmd_* inputs are ignored while cmd_ready = 0.
- Reset mid-transfer drops psel/penable asynchronously and produces no done pulse.

Optional Feature:
RELAY_SEQ_PREADY_WATCHDOG_EN:
- Defined: a 16-bit counter runs in WR_ACCESS/RD_ACCESS. If pready has not arrived within 65535 cycles, the sequencer aborts the transfer, deasserts psel/penable, and finishes with err_code 3. The counter clears on each setup phase.
- Undefined: the access phase waits on pready indefinitely and no watchdog logic is generated.

Test Plan:
- Completer with busy held for 3 polls, POLL_GAP = 4, command ch = 2, dir = 1 -> write pwdata = 16'h8002 at 0x0000; 4 status reads at 0x0020; done with err = 0, code 0; busy throughout.
- Completer returns pslverr on the write -> no status reads; done with err_code 1 one cycle after the write access.
- Busy never clears, MAX_POLLS = 8 -> exactly 8 reads, then done with err_code 3.
- Completer inserts 5 wait states per access -> paddr/pwdata/pwrite stay stable across the wait, penable is held, and results are identical to the zero-wait case.
- Assert preset_n low during RD_ACCESS -> psel/penable go to 0 immediately, no done pulse, and cmd_ready = 1 after release; the next command completes normally.
- cmd_valid held high continuously -> commands are accepted only in IDLE, one done per command, with an idle APB cycle between consecutive transfers.
